// File: rtl/snitch_ssr_addr_gen_nd_if.sv
// Config and address-stream bundle between the SSR config file, the address generator and the lane mover.
// The master drives config writes and address acceptance; the slave returns read data and the address stream.
interface snitch_ssr_addr_gen_nd_if #(
  parameter int unsigned RptWidth  = 4,
  parameter int unsigned AddrWidth = 32
);
  logic [4:0]           cfg_word_i;
  logic [31:0]          cfg_wdata_i;
  logic                 cfg_write_i;
  logic                 cfg_wready_o;
  logic [31:0]          cfg_rdata_o;
  logic [RptWidth-1:0]  reg_rep_o;
  logic [AddrWidth-1:0] mem_addr_o;
  logic                 mem_write_o;
  logic                 mem_last_o;
  logic                 mem_valid_o;
  logic                 mem_ready_i;
  logic                 job_done_o;
  logic                 busy_o;

  modport master (
    output cfg_word_i, cfg_wdata_i, cfg_write_i, mem_ready_i,
    input  cfg_wready_o, cfg_rdata_o, reg_rep_o, mem_addr_o, mem_write_o,
           mem_last_o, mem_valid_o, job_done_o, busy_o
  );

  modport slave (
    input  cfg_word_i, cfg_wdata_i, cfg_write_i, mem_ready_i,
    output cfg_wready_o, cfg_rdata_o, reg_rep_o, mem_addr_o, mem_write_o,
           mem_last_o, mem_valid_o, job_done_o, busy_o
  );
endinterface

// File: rtl/snitch_ssr_addr_gen_nd.sv
// N-loop affine SSR address generator with a one-deep shadow job and optional ring-buffer wrap window.
// Launch to first valid: 2 edges when idle; mem_ready_i stalls the stream, cfg_wready_o drops while a shadow job is pending.
module snitch_ssr_addr_gen_nd #(
  parameter int unsigned NumLoops     = 4,
  parameter int unsigned PointerWidth = 18,
  parameter int unsigned IndexWidth   = 16,
  parameter int unsigned RptWidth     = 4,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  snitch_ssr_addr_gen_nd_if.slave bus
);
  localparam int unsigned BytecntWidth = $clog2(DataWidth / 8);
  localparam logic [31:0] AlignMask    = ~((32'd1 << BytecntWidth) - 32'd1);

  typedef logic [PointerWidth-1:0] ptr_t;
  typedef logic [IndexWidth-1:0]   idx_t;

  // shadow set, written by config
  ptr_t                 shd_ptr;
  logic                 shd_write;
  logic [2:0]           shd_dims;
  logic [RptWidth-1:0]  shd_rep;
  idx_t                 shd_bound  [NumLoops];
  ptr_t                 shd_stride [NumLoops];
  logic [AddrWidth-1:0] shd_wbase;
  logic [AddrWidth-1:0] shd_wmask;
  logic                 pending;

  // active set, drives the stream
  ptr_t                 act_ptr;
  logic                 act_write;
  logic [2:0]           act_dims;
  logic [RptWidth-1:0]  act_rep;
  idx_t                 act_bound  [NumLoops];
  ptr_t                 act_stride [NumLoops];
  idx_t                 act_index  [NumLoops];
  logic [AddrWidth-1:0] act_wbase;
  logic [AddrWidth-1:0] act_wmask;
  logic                 act_done;

  logic                 job_done_q;
  logic [31:0]          wdata_al;
  logic                 wr_acc;
  logic [2:0]           dims_in;
  logic                 valid;
  logic                 hs;
  logic                 last;
  logic                 load;
  logic [NumLoops-1:0]  loop_last;
  logic [NumLoops-1:0]  loop_en;
  ptr_t                 step;
  logic [31:0]          rdata;
  logic [AddrWidth-1:0] ptr_ext;

  assign wdata_al = bus.cfg_wdata_i & AlignMask;
  assign wr_acc   = bus.cfg_write_i & ~pending;
  assign dims_in  = ({1'b0, bus.cfg_wdata_i[29:27]} >= 4'(NumLoops)) ? 3'(NumLoops - 1)
                                                                     : bus.cfg_wdata_i[29:27];
  assign valid    = ~act_done;
  assign hs       = valid & bus.mem_ready_i;
  assign last     = &loop_last;
  // zero-bubble handoff: the shadow job loads on the final handshake edge of the active one
  assign load     = pending & (act_done | (hs & last));

  always_comb begin
    logic en;
    loop_last = '0;
    loop_en   = '0;
    step      = '0;
    en        = 1'b1;
    for (int i = 0; i < NumLoops; i++) begin
      loop_last[i] = (act_index[i] == act_bound[i]) || (i > int'(act_dims));
      loop_en[i]   = en;
      en           = en & loop_last[i];
      if (loop_en[i]) step = act_stride[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shd_ptr    <= '0;
      shd_write  <= 1'b0;
      shd_dims   <= '0;
      shd_rep    <= '0;
      shd_wbase  <= '0;
      shd_wmask  <= '0;
      pending    <= 1'b0;
      act_ptr    <= '0;
      act_write  <= 1'b0;
      act_dims   <= '0;
      act_rep    <= '0;
      act_wbase  <= '0;
      act_wmask  <= '0;
      act_done   <= 1'b1;
      job_done_q <= 1'b0;
      for (int i = 0; i < NumLoops; i++) begin
        shd_bound[i]  <= '0;
        shd_stride[i] <= '0;
        act_bound[i]  <= '0;
        act_stride[i] <= '0;
        act_index[i]  <= '0;
      end
    end else begin
      job_done_q <= hs & last;

      if (wr_acc) begin
        if (bus.cfg_word_i == 5'd0) begin
          shd_ptr   <= PointerWidth'(wdata_al);
          shd_write <= bus.cfg_wdata_i[30];
          shd_dims  <= dims_in;
          pending   <= 1'b1;
        end
        if (bus.cfg_word_i == 5'd1)  shd_rep   <= RptWidth'(bus.cfg_wdata_i);
        if (bus.cfg_word_i == 5'd18) shd_wbase <= AddrWidth'(wdata_al);
        if (bus.cfg_word_i == 5'd19) shd_wmask <= AddrWidth'(wdata_al);
        for (int i = 0; i < NumLoops; i++) begin
          if (bus.cfg_word_i == 5'(2 + i))  shd_bound[i]  <= IndexWidth'(bus.cfg_wdata_i);
          if (bus.cfg_word_i == 5'(10 + i)) shd_stride[i] <= PointerWidth'(wdata_al);
        end
      end

      if (load) begin
        act_ptr   <= shd_ptr;
        act_write <= shd_write;
        act_dims  <= shd_dims;
        act_rep   <= shd_rep;
        act_wbase <= shd_wbase;
        act_wmask <= shd_wmask;
        act_done  <= 1'b0;
        pending   <= 1'b0;
        for (int i = 0; i < NumLoops; i++) begin
          act_bound[i]  <= shd_bound[i];
          act_stride[i] <= shd_stride[i];
          act_index[i]  <= '0;
        end
      end else if (hs) begin
        act_ptr <= act_ptr + step;
        if (last) act_done <= 1'b1;
        for (int i = 0; i < NumLoops; i++) begin
          if (loop_en[i]) act_index[i] <= loop_last[i] ? '0 : act_index[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.cfg_word_i == 5'd0)  rdata = {act_done, act_write, act_dims, 27'(act_ptr)};
    if (bus.cfg_word_i == 5'd1)  rdata = 32'(act_rep);
    if (bus.cfg_word_i == 5'd18) rdata = 32'(act_wbase);
    if (bus.cfg_word_i == 5'd19) rdata = 32'(act_wmask);
    for (int i = 0; i < NumLoops; i++) begin
      if (bus.cfg_word_i == 5'(2 + i))  rdata = 32'(act_bound[i]);
      if (bus.cfg_word_i == 5'(10 + i)) rdata = 32'(act_stride[i]);
    end
  end

  assign ptr_ext = AddrWidth'(act_ptr);

  assign bus.cfg_wready_o = ~pending;
  assign bus.cfg_rdata_o  = rdata;
  assign bus.reg_rep_o    = act_rep;
  assign bus.mem_addr_o   = (act_wmask != '0) ? ((act_wbase & ~act_wmask) | (ptr_ext & act_wmask))
                                              : ptr_ext;
  assign bus.mem_write_o  = act_write;
  assign bus.mem_last_o   = last;
  assign bus.mem_valid_o  = valid;
  assign bus.job_done_o   = job_done_q;
  assign bus.busy_o       = ~act_done | pending;
endmodule
